// File: rtl/state_pkg.sv
// Shared types and constants for the state register file client.
package state_pkg;

  localparam int POS_W   = 5;
  localparam int ADDR_W  = 12;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int CNT_W   = ADDR_W + 1;
  localparam int WDATA_W = POS_W + ADDR_W;
  localparam int ENTRY_W = 1 + POS_W + ADDR_W;

  // Bit positions inside an 18-bit state entry {done, pos, param_addr}
  localparam int DONE_BIT = 17;
  localparam int POS_LSB  = 12;

  localparam logic [1:0] OP_PUSH   = 2'b00;
  localparam logic [1:0] OP_NEXT   = 2'b01;
  localparam logic [1:0] OP_LOOKUP = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  // A command is rejected when it cannot be serviced with the counters as they
  // stand before the command itself is applied.
  function automatic logic cmd_is_error(input logic [1:0]        op,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [CNT_W-1:0]  wr_cnt,
                                        input logic [CNT_W-1:0]  rd_cnt);
    logic err;
    err = 1'b0;
    case (op)
      OP_PUSH:   err = (wr_cnt == CNT_W'(DEPTH));
      OP_NEXT:   err = (rd_cnt == wr_cnt);
      OP_LOOKUP: err = ({1'b0, addr} >= wr_cnt);
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/state_issuer_if.sv
// Command and response channels between the recursion scheduler and the issuer.
interface state_issuer_if;
  import state_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [POS_W-1:0]    cmd_pos;
  logic [ADDR_W-1:0]   cmd_addr;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_op;
  logic                rsp_err;
  logic [ADDR_W-1:0]   rsp_index;
  logic [ENTRY_W-1:0]  rsp_data;

  // Scheduler side
  modport master (
    output cmd_valid, cmd_op, cmd_pos, cmd_addr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_op, rsp_err, rsp_index, rsp_data
  );

  // Issuer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_pos, cmd_addr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_op, rsp_err, rsp_index, rsp_data
  );

endinterface

// File: rtl/state_issuer.sv
// Sole master of the state register file: turns push/next/lookup commands into
// single-cycle regfile strobes and returns one response per command.
module state_issuer
  import state_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  state_issuer_if.slave       bus,
  output logic                st_we,
  output logic [WDATA_W-1:0]  st_w_data,
  output logic                st_seq_re,
  output logic                st_ran_re,
  output logic [ADDR_W-1:0]   st_ran_r_addr,
  input  logic [ADDR_W-1:0]   st_r_addr,
  input  logic [ENTRY_W-1:0]  st_r_data
);

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  // Mirrors of the regfile write and sequential-read pointers
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                we_q, we_d;
  logic                seq_re_q, seq_re_d;
  logic                ran_re_q, ran_re_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [1:0]          rsp_op_q, rsp_op_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]   rsp_index_q, rsp_index_d;
  logic [ENTRY_W-1:0]  rsp_data_q, rsp_data_d;

  logic                cmd_err;

  assign cmd_err = cmd_is_error(bus.cmd_op, bus.cmd_addr, wr_cnt_q, rd_cnt_q);

  // Next-state and next-output logic; strobes default low so each lasts one cycle
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pos_d       = pos_q;
    addr_d      = addr_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    cmd_ready_d = cmd_ready_q;
    we_d        = 1'b0;
    seq_re_d    = 1'b0;
    ran_re_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_op_d    = rsp_op_q;
    rsp_err_d   = rsp_err_q;
    rsp_index_d = rsp_index_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d        = bus.cmd_op;
          pos_d       = bus.cmd_pos;
          addr_d      = bus.cmd_addr;
          cmd_ready_d = 1'b0;
          if (cmd_err) begin
            // Rejected commands skip the regfile entirely
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_op_d    = bus.cmd_op;
            rsp_err_d   = 1'b1;
            rsp_index_d = bus.cmd_addr;
            rsp_data_d  = '0;
          end else begin
            state_d = S_ISSUE;
            case (bus.cmd_op)
              OP_PUSH:   we_d     = 1'b1;
              OP_NEXT:   seq_re_d = 1'b1;
              OP_LOOKUP: ran_re_d = 1'b1;
              default:   ;
            endcase
          end
        end
      end

      S_ISSUE: begin
        // The regfile presents the read entry during the strobe cycle
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_op_d    = op_q;
        rsp_err_d   = 1'b0;
        case (op_q)
          OP_PUSH: begin
            rsp_index_d = wr_cnt_q[ADDR_W-1:0];
            rsp_data_d  = '0;
            wr_cnt_d    = wr_cnt_q + CNT_W'(1);
          end
          OP_NEXT: begin
            rsp_index_d = st_r_addr;
            rsp_data_d  = st_r_data;
            rd_cnt_d    = rd_cnt_q + CNT_W'(1);
          end
          default: begin
            rsp_index_d = st_r_addr;
            rsp_data_d  = st_r_data;
          end
        endcase
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset drops any command or response in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      pos_q       <= '0;
      addr_q      <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      cmd_ready_q <= 1'b1;
      we_q        <= 1'b0;
      seq_re_q    <= 1'b0;
      ran_re_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_err_q   <= 1'b0;
      rsp_index_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pos_q       <= pos_d;
      addr_q      <= addr_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      we_q        <= we_d;
      seq_re_q    <= seq_re_d;
      ran_re_q    <= ran_re_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_err_q   <= rsp_err_d;
      rsp_index_q <= rsp_index_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_op    = rsp_op_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_index = rsp_index_q;
  assign bus.rsp_data  = rsp_data_q;

  assign st_we         = we_q;
  assign st_w_data     = {pos_q, addr_q};
  assign st_seq_re     = seq_re_q;
  assign st_ran_re     = ran_re_q;
  assign st_ran_r_addr = addr_q;

endmodule

// File: doc/state_issuer.md
# state_issuer

Client-side controller for the InexRecur state register file: the block that writes new state entries into it and reads them back. It accepts push / next / lookup commands from the recursion scheduler over a valid/ready channel. It drives the state regfile's write, sequential-read and random-read strobes, never driving both read strobes in the same cycle. It returns each result over a valid/ready response channel. It is the only master of the state regfile's ports and mirrors the regfile's write and sequential-read pointers internally.

## Interface
- POS_W, 5, call-position field width
- ADDR_W, 12, parameter-address / entry-index width
- DEPTH, 4096, number of state entries (2**ADDR_W)

Ports (clock and reset first):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  00 push, 01 next, 10 lookup, 11 reserved
- cmd_pos  in  POS_W  push: call position
- cmd_addr  in  ADDR_W  push: parameter address; lookup: entry index
- rsp_valid  out  1  response held
- rsp_ready  in  1  response consumed
- rsp_op  out  2  echo of cmd_op
- rsp_err  out  1  command rejected (full / empty / bad index / reserved op)
- rsp_index  out  ADDR_W  entry index written or read
- rsp_data  out  18  {done, pos[4:0], param_addr[11:0]}; 0 for push and on error
- st_we  out  1  regfile write strobe
- st_w_data  out  17  {pos, param_addr}
- st_seq_re  out  1  regfile sequential read strobe
- st_ran_re  out  1  regfile random read strobe
- st_ran_r_addr  out  ADDR_W  random read index
- st_r_addr  in  ADDR_W  index of the entry presented by the regfile
- st_r_data  in  18  entry presented by the regfile, valid in the same cycle as the read strobe

## Operation
- Counters: wr_cnt (ADDR_W+1 bits) counts entries written; rd_cnt (ADDR_W+1 bits) counts entries consumed by next. Invariant: rd_cnt <= wr_cnt <= DEPTH.
- FSM states:
  - IDLE: cmd_ready=1. On accept, latch op/pos/addr and evaluate the error condition, then go to ISSUE. If the command is an error, go directly to RESP instead.
  - ISSUE: cmd_ready=0. Assert exactly one strobe for exactly one cycle. At the end of the cycle, capture st_r_addr/st_r_data, update counters, and go to RESP.
  - RESP: rsp_valid=1 and all outputs stable. On rsp_ready, go to IDLE.
- push: st_we=1 and st_w_data={pos,addr}. rsp_index=wr_cnt[ADDR_W-1:0]. wr_cnt increments.
- next: st_seq_re=1. rsp_index=st_r_addr and rsp_data=st_r_data. rd_cnt increments.
- lookup: st_ran_re=1 and st_ran_r_addr=latched addr. rsp_index=st_r_addr and rsp_data=st_r_data. No counter change.
- Error conditions, each of which gives rsp_err=1, no strobe and no counter change:
  - push when wr_cnt==DEPTH (full)
  - next when rd_cnt==wr_cnt (empty)
  - lookup with addr >= wr_cnt
  - op 11
- For errors, rsp_index is the latched cmd_addr and rsp_data is 0.
- st_seq_re and st_ran_re are never high together. st_we is never high together with either read strobe.

## Timing
- Reset (async, any state): state goes to IDLE and both counters clear. All strobes, rsp_valid, rsp_err, rsp_op, rsp_index and rsp_data go to 0. cmd_ready is 1 once reset is deasserted. A command or response in flight is dropped.
- Accept at edge N. The strobe is high during cycle N+1. rsp_valid rises in cycle N+2. Error commands raise rsp_valid in cycle N+1.
- Minimum command spacing is 3 cycles (2 for errors) when rsp_ready is tied high.
- rsp_ready low holds RESP indefinitely, with all response fields stable and cmd_ready low.
- Counter comparisons use the values before the command's own update.

## Structure
- Shared package state_pkg holds:
  - OP_PUSH/OP_NEXT/OP_LOOKUP/OP_RSVD codes
  - POS_W, ADDR_W, DEPTH
  - entry field offsets: DONE_BIT=17, POS_LSB=12
  - FSM state encoding
- Single module, no sub-module. The integration level inverts rst to drive the regfile's active-low reset.

## Test plan
- Reset, then push pos=3 addr=0x0A5 → st_we high for one cycle with st_w_data=0x030A5; response has rsp_err=0, rsp_index=0, rsp_data=0.
- Push 3 entries, then issue next ×3 followed by a 4th next → first three return rsp_index 0,1,2 with matching pos/addr; the 4th returns rsp_err=1 and no st_seq_re pulse.
- After 5 pushes: lookup 4 → st_ran_re=1 with st_ran_r_addr=4 and data returned; lookup 5 → rsp_err=1 with no strobe.
- Fill to 4096 entries, then push again → rsp_err=1 with no st_we; next ×4096 returns indices 0..4095 in order.
- Hold rsp_ready low for 10 cycles → rsp_valid and fields stay stable and cmd_ready stays 0; a cmd_valid offered during the hold is not accepted until 1 cycle after rsp_ready.
- Assert rst during ISSUE of a push → strobes drop immediately; after release wr_cnt=0 and next returns rsp_err=1.
- All scenarios: a monitor flags any cycle with two strobes high.
